// File: rtl/seg_entry_ctrl_pkg.sv
// rtl/seg_entry_ctrl_pkg.sv - segment patterns, mode encoding and decode helper for seg_entry_ctrl
package seg_entry_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic MODE_FILL  = 1'b0;
   localparam logic MODE_SHIFT = 1'b1;

   typedef enum logic {
      DEB_RELEASED = 1'b0,
      DEB_PRESSED  = 1'b1
   } deb_state_t;

   // Letters are suppressed to blank when hex display is off.
   function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic hex_en);
      logic [6:0] res;
      case (value)
         4'h0: res = SEG_0;
         4'h1: res = SEG_1;
         4'h2: res = SEG_2;
         4'h3: res = SEG_3;
         4'h4: res = SEG_4;
         4'h5: res = SEG_5;
         4'h6: res = SEG_6;
         4'h7: res = SEG_7;
         4'h8: res = SEG_8;
         4'h9: res = SEG_9;
         4'hA: res = hex_en ? SEG_A : SEG_BLANK;
         4'hB: res = hex_en ? SEG_B : SEG_BLANK;
         4'hC: res = hex_en ? SEG_C : SEG_BLANK;
         4'hD: res = hex_en ? SEG_D : SEG_BLANK;
         4'hE: res = hex_en ? SEG_E : SEG_BLANK;
         default: res = hex_en ? SEG_F : SEG_BLANK;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg_entry_ctrl_if.sv
// rtl/seg_entry_ctrl_if.sv - entry inputs and display outputs of seg_entry_ctrl
interface seg_entry_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic [3:0]              digit_in;
   logic                    btn_n;
   logic                    clr;
   logic                    mode;
   logic                    hex_en;
   logic [7*NUM_DIGITS-1:0] seg_out;
   logic [CW-1:0]           count;
   logic                    full;
   logic                    load_pulse;

   modport master (
      output digit_in, btn_n, clr, mode, hex_en,
      input  seg_out, count, full, load_pulse
   );

   modport slave (
      input  digit_in, btn_n, clr, mode, hex_en,
      output seg_out, count, full, load_pulse
   );
endinterface

// File: rtl/seg_entry_ctrl_debounce.sv
// rtl/seg_entry_ctrl_debounce.sv - two-flop synchroniser and RELEASED/PRESSED debouncer
module seg_debounce
   import seg_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic       sync1, btn_s;
   logic [DW-1:0] cnt;
   deb_state_t state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         btn_s <= 1'b1;
         cnt   <= '0;
         state <= DEB_RELEASED;
      end else begin
         sync1 <= btn_n;
         btn_s <= sync1;
         case (state)
            DEB_RELEASED: begin
               if (btn_s)           cnt <= '0;
               else if (cnt == LAST) begin
                  state <= DEB_PRESSED;
                  cnt   <= '0;
               end else             cnt <= cnt + DW'(1);
            end
            default: begin
               if (!btn_s)          cnt <= '0;
               else if (cnt == LAST) begin
                  state <= DEB_RELEASED;
                  cnt   <= '0;
               end else             cnt <= cnt + DW'(1);
            end
         endcase
      end
   end

   // Strobe is the transition condition itself, so storage updates on the edge that enters PRESSED.
   assign press = (state == DEB_RELEASED) && !btn_s && (cnt == LAST);

endmodule

// File: rtl/seg_entry_ctrl.sv
// rtl/seg_entry_ctrl.sv - debounced digit entry onto NUM_DIGITS seven-segment displays
// Optional cursor blink: SEG_ENTRY_CURSOR_BLINK_EN
module seg_entry_ctrl
   import seg_entry_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int BLINK_CYCLES    = 31250000
) (
   input  logic             CLOCK_125_p,
   input  logic             rst,
   seg_entry_ctrl_if.slave  bus
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic                    press;
   logic [3:0]              val_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   vld_q;
   logic [CW-1:0]           count_q;
   logic                    load_q;
   logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
   logic                    full;
   logic                    cursor_on;

   seg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (CLOCK_125_p),
      .rst   (rst),
      .btn_n (bus.btn_n),
      .press (press)
   );

   assign full = (count_q == CW'(NUM_DIGITS));

`ifdef SEG_ENTRY_CURSOR_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   logic [BW-1:0] blink_cnt;
   logic          blink_off;

   always_ff @(posedge CLOCK_125_p or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (bus.clr || press) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   assign cursor_on = (bus.mode == MODE_FILL) && !full && !blink_off;
`else
   assign cursor_on = 1'b0;
`endif

   always_comb begin
      seg_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (vld_q[i])
            seg_d[7*i +: 7] = seg_decode(val_q[i], bus.hex_en);
         else if (cursor_on && count_q == CW'(i))
            seg_d[7*i +: 7] = SEG_DASH;
      end
   end

   always_ff @(posedge CLOCK_125_p or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) val_q[i] <= '0;
         vld_q   <= '0;
         count_q <= '0;
         load_q  <= 1'b0;
         seg_q   <= '1;
      end else begin
         load_q <= press && !bus.clr;
         seg_q  <= seg_d;
         if (bus.clr) begin
            vld_q   <= '0;
            count_q <= '0;
         end else if (press) begin
            if (bus.mode == MODE_SHIFT) begin
               for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                  val_q[i] <= val_q[i-1];
                  vld_q[i] <= vld_q[i-1];
               end
               val_q[0] <= bus.digit_in;
               vld_q[0] <= 1'b1;
               if (!full) count_q <= count_q + CW'(1);
            end else if (!full) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (count_q == CW'(i)) begin
                     val_q[i] <= bus.digit_in;
                     vld_q[i] <= 1'b1;
                  end
               end
               count_q <= count_q + CW'(1);
            end
         end
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.count      = count_q;
   assign bus.full       = full;
   assign bus.load_pulse = load_q;

endmodule

// File: tb/tb_seg_entry_ctrl.sv
// tb/tb_seg_entry_ctrl.sv - directed and randomized checks of seg_entry_ctrl against a digit-list model
module tb_seg_entry_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   seg_entry_ctrl_if #(.NUM_DIGITS(4)) bus ();

   seg_entry_ctrl #(
      .NUM_DIGITS      (4),
      .DEBOUNCE_CYCLES (4),
      .BLINK_CYCLES    (8)
   ) dut (
      .CLOCK_125_p (clk),
      .rst         (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: list of entered digits, m_val[i]/m_vld[i] per display position.
   int m_val [4];
   bit m_vld [4];
   int m_cnt;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin m_vld[i] = 0; m_val[i] = 0; end
      m_cnt = 0;
   endtask

   task automatic model_press(input int v, input bit shift_mode);
      if (shift_mode) begin
         for (int i = 3; i > 0; i--) begin m_val[i] = m_val[i-1]; m_vld[i] = m_vld[i-1]; end
         m_val[0] = v; m_vld[0] = 1;
         m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      end else if (m_cnt < 4) begin
         m_val[m_cnt] = v; m_vld[m_cnt] = 1;
         m_cnt = m_cnt + 1;
      end
   endtask

   function automatic logic [27:0] exp_seg(input bit hx);
      logic [27:0] r;
      r = '1;
      for (int i = 0; i < 4; i++)
         if (m_vld[i] && (m_val[i] < 10 || hx)) r[7*i +: 7] = pat[m_val[i]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seg(input string tag);
      logic [27:0] mask;
      mask = '0;
`ifdef SEG_ENTRY_CURSOR_BLINK_EN
      if (bus.mode == 1'b0 && m_cnt < 4) mask[7*m_cnt +: 7] = '1;
`endif
      chk(tag, {4'h0, bus.seg_out | mask}, {4'h0, exp_seg(bus.hex_en) | mask});
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"}, {29'd0, bus.count}, m_cnt);
      chk({tag, "_full"}, {31'd0, bus.full}, {31'd0, m_cnt == 4});
   endtask

   // Holds the button low for 8 edges then releases for 8; press event expected after edge 6.
   task automatic press(input logic [3:0] v, input bit with_clr);
      bus.digit_in = v;
      bus.btn_n    = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 6) begin
            if (with_clr) model_clear(); else model_press(v, bus.mode);
            chk("load_pulse_edge6", {31'd0, bus.load_pulse}, {31'd0, !with_clr});
            chk_state("after_press");
            bus.clr = 1'b0;
         end else begin
            chk("load_pulse_quiet", {31'd0, bus.load_pulse}, 32'd0);
         end
         if (k == 7) chk_seg("seg_after_press");
         if (k == 5 && with_clr) bus.clr = 1'b1;
      end
      bus.btn_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("load_pulse_release", {31'd0, bus.load_pulse}, 32'd0);
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      model_clear();
      chk_state("clear");
      @(negedge clk);
      chk_seg("seg_after_clear");
   endtask

   initial begin
      rst = 1'b1;
      bus.digit_in = '0;
      bus.btn_n    = 1'b1;
      bus.clr      = 1'b0;
      bus.mode     = 1'b0;
      bus.hex_en   = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_seg", {4'h0, bus.seg_out}, 32'h0FFFFFFF);
      chk_state("reset");
      chk("reset_load_pulse", {31'd0, bus.load_pulse}, 32'd0);
      rst = 1'b0;

      // Glitch shorter than the debounce window
      @(negedge clk);
      bus.btn_n = 1'b0;
      repeat (3) @(negedge clk);
      bus.btn_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("glitch_no_pulse", {31'd0, bus.load_pulse}, 32'd0);
      end

      // Fill mode 1,5,9,5 then a press on a full display
      press(4'h1, 0);
      press(4'h5, 0);
      press(4'h9, 0);
      press(4'h5, 0);
      chk("fill_digits", {4'h0, bus.seg_out}, {4'h0, 7'b0010010, 7'b0010000, 7'b0010010, 7'b1111001});
      press(4'h7, 0);
      chk("full_unchanged", {4'h0, bus.seg_out}, {4'h0, 7'b0010010, 7'b0010000, 7'b0010010, 7'b1111001});

      // Shift mode with hex letters
      do_clear();
      bus.mode   = 1'b1;
      bus.hex_en = 1'b1;
      press(4'hA, 0);
      press(4'hB, 0);
      press(4'hC, 0);
      press(4'hD, 0);
      press(4'hE, 0);
      chk("shift_digit0_E", {25'd0, bus.seg_out[6:0]}, 32'b0000110);
      chk("shift_digit3_B", {25'd0, bus.seg_out[27:21]}, 32'b0000011);
      chk("shift_count", {29'd0, bus.count}, 32'd4);
      bus.hex_en = 1'b0;
      chk("hex_off_latency", {4'h0, bus.seg_out}, {4'h0, exp_seg(1'b1)});
      @(negedge clk);
      chk("hex_off_blank", {4'h0, bus.seg_out}, 32'h0FFFFFFF);

      // clr coinciding with a press event, then the next press lands on digit0
      bus.mode = 1'b0;
      press(4'h3, 1);
      chk("clr_press_blank", {4'h0, bus.seg_out}, 32'h0FFFFFFF);
      press(4'h8, 0);
      chk("after_clr_digit0", {25'd0, bus.seg_out[6:0]}, 32'b0000000);

      // Reset while the button is held re-arms the debouncer
      bus.btn_n = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      chk_state("reset_held");
      press(4'h6, 0);

      // Randomized entries with mode switching, hex_en and clears
      for (int n = 0; n < 20; n++) begin
         bus.mode   = 1'($urandom_range(0, 1));
         bus.hex_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) do_clear();
         press(4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
         chk_seg("random_seg");
      end

      // Cursor: one fill load, digit1 observed over three half-periods
      do_clear();
      bus.mode = 1'b0;
      press(4'h2, 0);
      for (int j = 17; j <= 40; j++) begin
         @(negedge clk);
`ifdef SEG_ENTRY_CURSOR_BLINK_EN
         chk("cursor_blink", {25'd0, bus.seg_out[13:7]},
             ((((j - 7) / 8) % 2) == 0) ? 32'h3F : 32'h7F);
`else
         chk("cursor_blank", {25'd0, bus.seg_out[13:7]}, 32'h7F);
`endif
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/seg_entry_ctrl.md
Name: seg_entry_ctrl

Overview:
- Parametrised successor to the board's four-digit switch-entry display logic.
- Lets the user enter digits one at a time: a 4-bit value is presented on digit_in, then a debounced button press stores it on one of NUM_DIGITS seven-segment digits.
- Supports two entry modes (fill and shift), hex decoding, clear and a full flag.
- Sits between the board KEY/SW pins and the HEX outputs of the top level.

Parameters:
- NUM_DIGITS, 4: number of seven-segment digits driven (1..8).
- DEBOUNCE_CYCLES, 1250000: consecutive stable cycles needed to accept a button level change (10 ms at 125 MHz); benches use 4.
- BLINK_CYCLES, 31250000: half-period of the cursor blink; used only with the optional feature; benches use 8.

Ports:
- CLOCK_125_p  input  1  system clock, 125 MHz.
- rst  input  1  asynchronous reset, active-high.
- digit_in  input  4  value to load, from SW[3:0].
- btn_n  input  1  raw load button, active-low, asynchronous (KEY).
- clr  input  1  synchronous clear, active-high, one cycle is sufficient.
- mode  input  1  0 = fill (left-to-right by index), 1 = shift-in at digit 0.
- hex_en  input  1  1 = show values 10..15 as A b C d E F; 0 = show them blank.
- seg_out  output  7*NUM_DIGITS  active-low segments; digit i occupies bits [7i+6:7i], bit order gfedcba.
- count  output  $clog2(NUM_DIGITS+1)  number of digits entered, saturating at NUM_DIGITS.
- full  output  1  high when count == NUM_DIGITS.
- load_pulse  output  1  one-cycle strobe on each accepted press.

Behaviour:
- Reset (async, rst=1):
  - every digit is empty; seg_out is all ones (blank).
  - count=0, full=0, load_pulse=0.
  - debouncer is in RELEASED with its counter at 0.
- Synchroniser: btn_n passes through two flops; the second flop output is btn_s.
- Debouncer states are RELEASED and PRESSED.
  - In RELEASED, the counter increments while btn_s=0 and clears when btn_s=1.
  - When the counter reaches DEBOUNCE_CYCLES-1 while btn_s=0, the next edge moves the FSM to PRESSED and generates a press event.
  - PRESSED works symmetrically with btn_s=1 and returns to RELEASED with no event.
  - The counter clears on every state change.
- Latency for a clean low step on btn_n: the press event (load_pulse=1) is visible after rising edge number DEBOUNCE_CYCLES+2, counting the first edge that samples btn_n low as edge 1.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Storage: each digit holds a 4-bit value and a valid bit. On a press event, at the same edge that raises load_pulse:
  - mode=0, full=0: digit[count] gets digit_in and becomes valid; count increments.
  - mode=0, full=1: the press is ignored. load_pulse still pulses, and no digit changes (no wrap).
  - mode=1: digit[i] gets digit[i-1] for i>0, and digit[0] gets digit_in. The oldest digit falls off. count increments, saturating at NUM_DIGITS.
- mode is sampled only at the press event. Changing mode mid-entry keeps count and the digit contents.
- clr: on the next edge all digits become invalid and count=0.
  - clr has priority over a press event in the same cycle; the press is discarded and load_pulse=0.
  - clr does not reset the debouncer.
- Decode: seg_out is registered and reflects storage one cycle after load_pulse.
  - Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - With hex_en=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - With hex_en=0, values 10..15 display blank (1111111).
  - Invalid digits display blank.
  - hex_en applies live, with one cycle of latency.
- full is combinational from count.
- rst while the button is held: the debouncer returns to RELEASED, so a press event is generated again after DEBOUNCE_CYCLES of low input.

Optional Feature:
- Macro: SEG_ENTRY_CURSOR_BLINK_EN.
- Defined:
  - In mode 0 with full=0, digit[count] shows the dash 0111111 for BLINK_CYCLES cycles, then blank for BLINK_CYCLES cycles, repeating.
  - The blink counter resets on rst, on clr and on each load_pulse, starting in the dash phase.
  - No cursor appears in mode 1 or when full=1.
- Undefined: there is no blink counter and the cursor digit is plain blank; BLINK_CYCLES is unused.

Decomposition:
- Package seg_entry_pkg holds:
  - the 16 segment pattern constants, SEG_BLANK (7'h7F) and SEG_DASH (7'h3F);
  - the mode encoding constants MODE_FILL=0 and MODE_SHIFT=1;
  - a seg_decode(value, hex_en) function.
- Sub-module seg_debounce contains the synchroniser, the counter and the RELEASED/PRESSED FSM. It is parametrised by DEBOUNCE_CYCLES and outputs a one-cycle press strobe.

Test Plan:
All scenarios use NUM_DIGITS=4, DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
1. Reset: rst=1 pulse → seg_out=28'hFFFFFFF, count=0, full=0, load_pulse=0.
2. Debounce: a 3-cycle low glitch on btn_n → no load_pulse. A held-low step → load_pulse at edge 6 only, and a single pulse per hold.
3. Fill mode: load 1,5,9,5 → digit0..3 show 1111001, 0010010, 0010000, 0010010; full=1. A fifth press with digit_in=7 → load_pulse=1 and no digit changes.
4. Shift mode with hex_en=1: load A,B,C,D,E → digit0=E (0000110), digit3=B (0000011), count=4. Setting hex_en=0 → those digits go blank one cycle later.
5. clr asserted in the same cycle as a press event → load_pulse=0, all digits blank, count=0. The next press writes digit0.
6. With SEG_ENTRY_CURSOR_BLINK_EN: after one fill load, digit1 toggles between 0111111 and 1111111 every 8 cycles. With the macro undefined, digit1 stays 1111111.
